// File: rtl/keypad_conditioner_pkg.sv
// Shared types for the digital lock keypad front end:
// debouncer and arbiter state encodings, default key count.
package digital_lock_pkg;

    localparam int KEY_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Map a synchronised pin level to 1 = pressed.
    function automatic logic pressed_level(logic raw, logic active_low);
        return raw ^ active_low;
    endfunction

endpackage

// File: rtl/keypad_conditioner_if.sv
// Keypad bundle: raw pins in, conditioned press code and status out.
// master = button/board side, slave = conditioner.
interface keypad_conditioner_if
#(
    parameter int KEY_COUNT = digital_lock_pkg::KEY_COUNT_DEFAULT
);
    logic [KEY_COUNT-1:0] key_raw;
    logic [KEY_COUNT-1:0] key;
    logic                 key_held;
    logic                 multi_press;

    modport master (
        output key_raw,
        input  key,
        input  key_held,
        input  multi_press
    );

    modport slave (
        input  key_raw,
        output key,
        output key_held,
        output multi_press
    );
endinterface

// File: rtl/keypad_conditioner_key_debouncer.sv
// One button: 2-flop synchroniser, polarity normalise,
// then a saturating-count debounce FSM emitting a press event.
module key_debouncer
    import digital_lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES + 1),
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic pressed_o,
    output logic press_evt_o,
    output logic released_o
);

    localparam logic IDLE_LVL = ACTIVE_LOW;
    localparam logic [COUNTER_WIDTH-1:0] TARGET =
        COUNTER_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    logic                     sync1_q;
    logic                     sync2_q;
    logic                     sample;
    deb_state_e               state_q;
    deb_state_e               state_d;
    logic [COUNTER_WIDTH-1:0] count_q;
    logic [COUNTER_WIDTH-1:0] count_d;
    logic [COUNTER_WIDTH-1:0] count_inc;
    logic                     evt_q;
    logic                     evt_d;

    // Two-flop synchroniser, parked at the idle pin level in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign sample    = pressed_level(sync2_q, ACTIVE_LOW);
    assign count_inc = (count_q >= TARGET) ? count_q : count_q + ONE;

    // Debounce FSM state, stable-sample counter and event flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RELEASED;
            count_q <= '0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            evt_q   <= evt_d;
        end
    end

    // Next state: a contrary sample extends the run, a matching one aborts it.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        evt_d   = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (sample) begin
                    if (ONE >= TARGET) begin
                        state_d = PRESSED;
                        count_d = '0;
                        evt_d   = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        count_d = ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!sample) begin
                    state_d = RELEASED;
                    count_d = '0;
                end else if (count_inc >= TARGET) begin
                    state_d = PRESSED;
                    count_d = '0;
                    evt_d   = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end
            PRESSED: begin
                if (!sample) begin
                    if (ONE >= TARGET) begin
                        state_d = RELEASED;
                        count_d = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        count_d = ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (sample) begin
                    state_d = PRESSED;
                    count_d = '0;
                end else if (count_inc >= TARGET) begin
                    state_d = RELEASED;
                    count_d = '0;
                end else begin
                    count_d = count_inc;
                end
            end
            default: begin
                state_d = RELEASED;
                count_d = '0;
            end
        endcase
    end

    assign pressed_o   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign released_o  = (state_q == RELEASED);
    assign press_evt_o = evt_q;

endmodule

// File: rtl/keypad_conditioner.sv
// Keypad front end: per-key debouncers plus a one-key-at-a-time arbiter.
// Optional KEYPAD_MULTIPRESS_ERROR_EN enables the multi_press pulse.
module keypad_conditioner
    import digital_lock_pkg::*;
#(
    parameter int CLOCK_HZ        = 50000000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int DEBOUNCE_CYCLES = CLOCK_HZ / 1000 * DEBOUNCE_MS,
    parameter int COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int KEY_COUNT       = KEY_COUNT_DEFAULT,
    parameter int KEYS_ACTIVE_LOW = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    keypad_conditioner_if.slave  kif
);

    logic [KEY_COUNT-1:0] evt;
    logic [KEY_COUNT-1:0] pressed;
    logic [KEY_COUNT-1:0] released;
    logic                 any_evt;
    logic                 single_evt;
    logic                 all_released;
    arb_state_e           arb_q;
    arb_state_e           arb_d;
    logic [KEY_COUNT-1:0] key_q;
    logic [KEY_COUNT-1:0] key_d;

    for (genvar i = 0; i < KEY_COUNT; i++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .COUNTER_WIDTH   (COUNTER_WIDTH),
            .ACTIVE_LOW      (KEYS_ACTIVE_LOW != 0)
        ) u_deb (
            .clock       (clock),
            .reset       (reset),
            .raw_i       (kif.key_raw[i]),
            .pressed_o   (pressed[i]),
            .press_evt_o (evt[i]),
            .released_o  (released[i])
        );
    end

    assign any_evt      = |evt;
    assign single_evt   = any_evt &&
                          ((evt & (evt - KEY_COUNT'(1))) == '0);
    assign all_released = &released;

    // Arbiter state and registered one-hot press code.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            arb_q <= IDLE;
            key_q <= '0;
        end else begin
            arb_q <= arb_d;
            key_q <= key_d;
        end
    end

    // Accept a lone event in IDLE; anything else just parks in HOLD.
    always_comb begin
        arb_d = arb_q;
        key_d = '0;
        unique case (arb_q)
            IDLE: begin
                if (any_evt) begin
                    arb_d = HOLD;
                    if (single_evt) key_d = evt;
                end
            end
            HOLD: begin
                if (all_released) arb_d = IDLE;
            end
            default: arb_d = IDLE;
        endcase
    end

    assign kif.key      = key_q;
    assign kif.key_held = |pressed;

`ifdef KEYPAD_MULTIPRESS_ERROR_EN
    logic mp_q;
    logic mp_d;

    // Flag events that the arbiter refused.
    always_comb begin
        mp_d = 1'b0;
        unique case (arb_q)
            IDLE:    mp_d = any_evt && !single_evt;
            HOLD:    mp_d = any_evt;
            default: mp_d = 1'b0;
        endcase
    end

    // Register the rejection pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mp_q <= 1'b0;
        else        mp_q <= mp_d;
    end

    assign kif.multi_press = mp_q;
`else
    assign kif.multi_press = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_conditioner.sv
// Bench for keypad_conditioner: directed scenarios plus random
// button activity, checked every cycle against a run-length model.
module tb_keypad_conditioner;

    localparam int K = 4;
    localparam int D = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   pulses = 0;
    int   mp_pulses = 0;
    logic [K-1:0] last_pulse = '0;

    keypad_conditioner_if #(.KEY_COUNT(K)) kif ();

    keypad_conditioner #(
        .CLOCK_HZ        (1000),
        .DEBOUNCE_MS     (4),
        .KEY_COUNT       (K),
        .KEYS_ACTIVE_LOW (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .kif   (kif.slave)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [K-1:0]      d1;
        logic [K-1:0]      d2;
        logic [K-1:0]      deb;
        logic [K-1:0]      evt;
        logic [K-1:0]      key;
        logic [K-1:0][7:0] run;
        logic              hold;
        logic              mp;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r    = '0;
        r.d1 = '1;
        r.d2 = '1;
        return r;
    endfunction

    // A key's clean level flips after D consecutive contrary samples;
    // one accepted press at a time, blocked until every key is quiet.
    function automatic model_t model_next(model_t c, logic [K-1:0] raw);
        model_t n;
        int     nev;
        logic   quiet;
        n     = c;
        n.d1  = raw;
        n.d2  = c.d1;
        nev   = 0;
        quiet = 1'b1;
        for (int k = 0; k < K; k++) begin
            if (c.deb[k] || c.run[k] != 8'd0) quiet = 1'b0;
            if (c.evt[k]) nev++;
            n.evt[k] = 1'b0;
            if ((~c.d2[k]) != c.deb[k]) begin
                if (int'(c.run[k]) + 1 >= D) begin
                    n.deb[k] = ~c.deb[k];
                    n.run[k] = 8'd0;
                    n.evt[k] = ~c.deb[k];
                end else begin
                    n.run[k] = c.run[k] + 8'd1;
                end
            end else begin
                n.run[k] = 8'd0;
            end
        end
        n.key = '0;
        n.mp  = 1'b0;
        if (!c.hold) begin
            if (nev == 1) begin
                n.key  = c.evt;
                n.hold = 1'b1;
            end else if (nev > 1) begin
                n.mp   = 1'b1;
                n.hold = 1'b1;
            end
        end else begin
            n.mp = (nev > 0);
            if (quiet) n.hold = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [K+1:0] exp_outs(model_t c);
        logic mpx;
`ifdef KEYPAD_MULTIPRESS_ERROR_EN
        mpx = c.mp;
`else
        mpx = 1'b0;
`endif
        return {c.key, |c.deb, mpx};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) m <= model_reset();
        else        m <= model_next(m, kif.key_raw);
    end

    always @(posedge clock) begin
        if (kif.key != '0) begin
            pulses     <= pulses + 1;
            last_pulse <= kif.key;
        end
        if (kif.multi_press) mp_pulses <= mp_pulses + 1;
    end

    task automatic test_reset();
        logic [K+1:0] obs;
        int p0;
        kif.key_raw = '0;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL reset_hold cyc%0d got %b want %b", i, obs, {(K+2){1'b0}});
            end
        end
        p0 = pulses;
        kif.key_raw = '1;
        reset = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== exp_outs(m)) begin
                miscompares++;
                $display("FAIL reset_release cyc%0d got %b want %b", i, obs, exp_outs(m));
            end
        end
        vectors++;
        if (pulses - p0 !== 0) begin
            miscompares++;
            $display("FAIL reset_no_pulse got %0d want 0", pulses - p0);
        end
    endtask

    task automatic test_single_press();
        logic [K+1:0] obs;
        logic [K-1:0] seen;
        int first, width;
        first = -1;
        width = 0;
        seen  = '0;
        @(negedge clock);
        kif.key_raw = 4'b0111;
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== exp_outs(m)) begin
                miscompares++;
                $display("FAIL press3 cyc%0d got %b want %b", j, obs, exp_outs(m));
            end
            if (kif.key != '0) begin
                if (first < 0) begin
                    first = j;
                    seen  = kif.key;
                end
                width++;
            end
        end
        vectors++;
        if (first !== D + 2 || width !== 1 || seen !== 4'b1000) begin
            miscompares++;
            $display("FAIL press3_timing got at=%0d w=%0d key=%b want at=%0d w=1 key=1000",
                     first, width, seen, D + 2);
        end
        vectors++;
        if (kif.key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL press3_held got %b want 1", kif.key_held);
        end
        kif.key_raw = '1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== exp_outs(m)) begin
                miscompares++;
                $display("FAIL release3 cyc%0d got %b want %b", j, obs, exp_outs(m));
            end
        end
        vectors++;
        if (kif.key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL release3_held got %b want 0", kif.key_held);
        end
    endtask

    task automatic test_bounce();
        logic [K+1:0] obs;
        logic [K-1:0] raw;
        int p0;
        p0  = pulses;
        raw = '1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== exp_outs(m)) begin
                miscompares++;
                $display("FAIL bounce cyc%0d got %b want %b", i, obs, exp_outs(m));
            end
            if (i % 2 == 0) raw[0] = ~raw[0];
            kif.key_raw = raw;
        end
        kif.key_raw = '1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== exp_outs(m)) begin
                miscompares++;
                $display("FAIL bounce_tail cyc%0d got %b want %b", i, obs, exp_outs(m));
            end
        end
        vectors++;
        if (pulses - p0 !== 0) begin
            miscompares++;
            $display("FAIL bounce_pulses got %0d want 0", pulses - p0);
        end
    endtask

    task automatic test_multi_press();
        logic [K+1:0] obs;
        int p0, q0, want_mp;
        p0 = pulses;
        q0 = mp_pulses;
`ifdef KEYPAD_MULTIPRESS_ERROR_EN
        want_mp = 1;
`else
        want_mp = 0;
`endif
        @(negedge clock);
        kif.key_raw = 4'b1001;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== exp_outs(m)) begin
                miscompares++;
                $display("FAIL multi cyc%0d got %b want %b", i, obs, exp_outs(m));
            end
            if (i == 9) kif.key_raw = '1;
        end
        vectors++;
        if (pulses - p0 !== 0 || mp_pulses - q0 !== want_mp) begin
            miscompares++;
            $display("FAIL multi_counts got key=%0d mp=%0d want key=0 mp=%0d",
                     pulses - p0, mp_pulses - q0, want_mp);
        end
    endtask

    task automatic test_hold_block();
        logic [K+1:0] obs;
        int p0;
        p0 = pulses;
        @(negedge clock);
        kif.key_raw = 4'b1110;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== exp_outs(m)) begin
                miscompares++;
                $display("FAIL hold cyc%0d got %b want %b", i, obs, exp_outs(m));
            end
            if (i == 11) kif.key_raw = 4'b1010;
            if (i == 25) begin
                vectors++;
                if (pulses - p0 !== 1 || last_pulse !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL hold_blocked got n=%0d last=%b want n=1 last=0001",
                             pulses - p0, last_pulse);
                end
                kif.key_raw = '1;
            end
            if (i == 40) kif.key_raw = 4'b1011;
        end
        vectors++;
        if (pulses - p0 !== 2 || last_pulse !== 4'b0100) begin
            miscompares++;
            $display("FAIL hold_reentry got n=%0d last=%b want n=2 last=0100",
                     pulses - p0, last_pulse);
        end
        @(negedge clock);
        kif.key_raw = '1;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        logic [K+1:0] obs;
        logic [K-1:0] seen;
        int first, width;
        first = -1;
        width = 0;
        seen  = '0;
        @(negedge clock);
        kif.key_raw = 4'b1101;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL midreset_hold cyc%0d got %b want 0", i, obs);
            end
        end
        reset = 1'b1;
        for (int j = 0; j < 14; j++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== exp_outs(m)) begin
                miscompares++;
                $display("FAIL midreset cyc%0d got %b want %b", j, obs, exp_outs(m));
            end
            if (kif.key != '0) begin
                if (first < 0) begin
                    first = j;
                    seen  = kif.key;
                end
                width++;
            end
        end
        vectors++;
        if (first !== D + 2 || width !== 1 || seen !== 4'b0010) begin
            miscompares++;
            $display("FAIL midreset_timing got at=%0d w=%0d key=%b want at=%0d w=1 key=0010",
                     first, width, seen, D + 2);
        end
        kif.key_raw = '1;
        repeat (12) @(negedge clock);
    endtask

    task automatic test_random();
        logic [K+1:0] obs;
        logic [K-1:0] raw;
        int idx;
        raw = '1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            obs = {kif.key, kif.key_held, kif.multi_press};
            vectors++;
            if (obs !== exp_outs(m)) begin
                miscompares++;
                $display("FAIL random cyc%0d got %b want %b", i, obs, exp_outs(m));
            end
            vectors++;
            if (!$onehot0(kif.key)) begin
                miscompares++;
                $display("FAIL random_onehot cyc%0d got %b want at most one bit", i, kif.key);
            end
            if ($urandom_range(5) == 0) begin
                idx = int'($urandom_range(K - 1));
                raw[idx] = ~raw[idx];
            end
            if (i >= 770) raw = '1;
            kif.key_raw = raw;
        end
    endtask

    initial begin
        kif.key_raw = '0;
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_press();
        test_hold_block();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
